// File: rtl/ram_stream_pkg.sv
// ram_stream_pkg: shared types and default widths for the RAM stream reader.
//   state_t            - reader FSM states (IDLE, RUN, FLUSH)
//   RAM_WIDTH_DEF      - default RAM data word width
//   RAM_ADDR_BITS_DEF  - default RAM address width
package ram_stream_pkg;
    localparam int RAM_WIDTH_DEF     = 16;
    localparam int RAM_ADDR_BITS_DEF = 10;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;
endpackage

// File: rtl/ram_stream_out_stage.sv
// ram_stream_out_stage: one-entry valid/ready output register.
//   clock, reset        - clock, asynchronous active-high reset
//   load, load_data     - capture load_data into the register (parent guarantees slot free or draining)
//   load_last           - last-beat flag captured with load (RAM_STREAM_LAST_EN only)
//   out_data, out_valid - stream payload and valid
//   out_last            - last-beat flag (RAM_STREAM_LAST_EN only)
//   out_ready           - consumer ready; a handshake without a load empties the register
// Optional feature macro: RAM_STREAM_LAST_EN adds load_last/out_last.
module ram_stream_out_stage
    import ram_stream_pkg::*;
#(
    parameter int WIDTH = RAM_WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
`ifdef RAM_STREAM_LAST_EN
    input  logic             load_last,
    output logic             out_last,
`endif
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef RAM_STREAM_LAST_EN
            out_last  <= 1'b0;
`endif
        end else if (load) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
`ifdef RAM_STREAM_LAST_EN
            out_last  <= load_last;
`endif
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks a wrap-around RAM address window and streams the words out.
//   clock, reset       - clock, asynchronous active-high reset
//   start              - job strobe, sampled only when idle
//   base_address       - first word of the window
//   length             - words to stream, 0..2**RAM_ADDR_BITS
//   busy               - job in progress (RUN or FLUSH)
//   done               - one-cycle pulse after the final handshake (or after a zero-length start)
//   read_address       - RAM asynchronous read address
//   ram_data           - RAM read data for read_address, same cycle
//   out_data/out_valid - output stream, out_ready from the consumer
//   out_last           - final-beat flag (RAM_STREAM_LAST_EN only)
// Optional feature macro: RAM_STREAM_LAST_EN.
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
    parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [RAM_ADDR_BITS-1:0] base_address,
    input  logic [RAM_ADDR_BITS:0]   length,
    output logic                     busy,
    output logic                     done,
    output logic [RAM_ADDR_BITS-1:0] read_address,
    input  logic [RAM_WIDTH-1:0]     ram_data,
    output logic [RAM_WIDTH-1:0]     out_data,
    output logic                     out_valid,
`ifdef RAM_STREAM_LAST_EN
    output logic                     out_last,
`endif
    input  logic                     out_ready
);
    localparam logic [RAM_ADDR_BITS:0] ONE = {{RAM_ADDR_BITS{1'b0}}, 1'b1};
    state_t                   state;
    logic [RAM_ADDR_BITS-1:0] address;
    logic [RAM_ADDR_BITS:0]   remaining;
    logic                     done_q;
    logic                     load;
    // The output register takes a new word whenever it is empty or draining this cycle;
    // while stalled the address holds, so the same word is re-read when load fires.
    assign load         = (state == RUN) && (!out_valid || out_ready);
    assign busy         = state != IDLE;
    assign done         = done_q;
    assign read_address = address;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            address   <= '0;
            remaining <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE && start) begin
                if (length != '0) begin
                    address   <= base_address;
                    remaining <= length;
                    state     <= RUN;
                end else begin
                    done_q <= 1'b1;
                end
            end
            if (load) begin
                address   <= address + ONE[RAM_ADDR_BITS-1:0];
                remaining <= remaining - ONE;
                if (remaining == ONE) state <= FLUSH;
            end
            if (state == FLUSH && out_valid && out_ready) begin
                done_q <= 1'b1;
                state  <= IDLE;
            end
        end
    end
    ram_stream_out_stage #(.WIDTH(RAM_WIDTH)) u_out (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .load_data (ram_data),
`ifdef RAM_STREAM_LAST_EN
        .load_last (remaining == ONE),
        .out_last  (out_last),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed self-checking bench for ram_stream_reader.
module tb_ram_stream_reader;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_address;
    logic [10:0] length;
    logic        busy;
    logic        done;
    logic [9:0]  read_address;
    logic [15:0] ram_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
`ifdef RAM_STREAM_LAST_EN
    logic        out_last;
`endif
    logic [15:0] mem [1024];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] got [$];
    int          last_at [$];
    int          first_valid;
    int          done_cyc;
    int          done_cnt;
    int          stall_bad;
    logic        busy0;
    logic [9:0]  ra0;

    always #5 clock = ~clock;
    assign ram_data = mem[read_address];

    ram_stream_reader dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .base_address (base_address),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .read_address (read_address),
        .ram_data     (ram_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
`ifdef RAM_STREAM_LAST_EN
        .out_last     (out_last),
`endif
        .out_ready    (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Issue a job, then observe cycle k (k=0 is the cycle after the start edge).
    // out_ready follows pat[k % plen]; inject re-strobes start mid-job.
    task automatic job(input logic [9:0] b, input logic [10:0] l, input logic [5:0] pat,
                       input int plen, input bit inject);
        logic        pv;
        logic [15:0] pd;
        got.delete();
        last_at.delete();
        first_valid = -1;
        done_cyc    = -1;
        done_cnt    = 0;
        stall_bad   = 0;
        pv          = 1'b0;
        pd          = '0;
        start        = 1'b1;
        base_address = b;
        length       = l;
        out_ready    = 1'b1;
        step();
        start = 1'b0;
        busy0 = busy;
        ra0   = read_address;
        for (int k = 0; k < 3000; k++) begin
            if (inject && k == 1) begin
                start        = 1'b1;
                base_address = 10'd0;
                length       = 11'd5;
            end else begin
                start = 1'b0;
            end
            out_ready = pat[k % plen];
            if (pv && !(out_valid === 1'b1 && out_data === pd)) stall_bad++;
            if (out_valid === 1'b1 && first_valid < 0) first_valid = k;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (out_valid === 1'b1 && out_ready) begin
                got.push_back(out_data);
`ifdef RAM_STREAM_LAST_EN
                if (out_last === 1'b1) last_at.push_back(got.size());
`endif
            end
            pv = out_valid === 1'b1 && !out_ready;
            pd = out_data;
            if (done_cyc >= 0 && k > done_cyc) break;
            step();
        end
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int bad;
        int dcount;
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i + 'h100);
        reset        = 1'b1;
        start        = 1'b0;
        base_address = '0;
        length       = '0;
        out_ready    = 1'b1;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_raddr", 32'(read_address), 32'd0);
        reset = 1'b0;
        step();

        // base 4, length 3, ready high
        job(10'd4, 11'd3, 6'b111111, 1, 1'b0);
        chk("j1_busy", 32'(busy0), 32'd1);
        chk("j1_raddr0", 32'(ra0), 32'd4);
        chk("j1_count", 32'(got.size()), 32'd3);
        chk("j1_b0", 32'(got[0]), 32'h104);
        chk("j1_b1", 32'(got[1]), 32'h105);
        chk("j1_b2", 32'(got[2]), 32'h106);
        chk("j1_first_valid", 32'(first_valid), 32'd1);
        chk("j1_done_cyc", 32'(done_cyc), 32'd4);
        chk("j1_done_cnt", 32'(done_cnt), 32'd1);
`ifdef RAM_STREAM_LAST_EN
        chk("j1_last_n", 32'(last_at.size()), 32'd1);
        chk("j1_last_at", 32'(last_at[0]), 32'd3);
`endif
        step();

        // wrap-around window
        job(10'd1022, 11'd4, 6'b111111, 1, 1'b0);
        chk("j2_raddr0", 32'(ra0), 32'd1022);
        chk("j2_count", 32'(got.size()), 32'd4);
        chk("j2_b0", 32'(got[0]), 32'h4FE);
        chk("j2_b1", 32'(got[1]), 32'h4FF);
        chk("j2_b2", 32'(got[2]), 32'h100);
        chk("j2_b3", 32'(got[3]), 32'h101);
        chk("j2_done_cyc", 32'(done_cyc), 32'd5);
        step();

        // backpressure: ready 1,0,0,1,0,1 repeating
        job(10'd1022, 11'd3, 6'b101001, 6, 1'b0);
        chk("j3_count", 32'(got.size()), 32'd3);
        chk("j3_b0", 32'(got[0]), 32'h4FE);
        chk("j3_b1", 32'(got[1]), 32'h4FF);
        chk("j3_b2", 32'(got[2]), 32'h100);
        chk("j3_stall_stable", 32'(stall_bad), 32'd0);
        chk("j3_done_cyc", 32'(done_cyc), 32'd7);
        chk("j3_done_cnt", 32'(done_cnt), 32'd1);
        step();

        // zero length
        job(10'd9, 11'd0, 6'b111111, 1, 1'b0);
        chk("j4_busy", 32'(busy0), 32'd0);
        chk("j4_count", 32'(got.size()), 32'd0);
        chk("j4_no_valid", 32'(first_valid), 32'hFFFF_FFFF);
        chk("j4_done_cyc", 32'(done_cyc), 32'd0);
        chk("j4_done_cnt", 32'(done_cnt), 32'd1);
        step();

        // start while busy is ignored
        job(10'd4, 11'd3, 6'b111111, 1, 1'b1);
        chk("j5_count", 32'(got.size()), 32'd3);
        chk("j5_b0", 32'(got[0]), 32'h104);
        chk("j5_b2", 32'(got[2]), 32'h106);
        chk("j5_done_cyc", 32'(done_cyc), 32'd4);
        chk("j5_busy_after", 32'(busy), 32'd0);
        step();

        // reset mid-job after two beats
        start        = 1'b1;
        base_address = 10'd4;
        length       = 11'd10;
        step();
        start = 1'b0;
        step();
        chk("rj_first", 32'(out_data), 32'h104);
        step();
        step();
        chk("rj_third", 32'(out_data), 32'h106);
        #2;
        reset = 1'b1;
        #1;
        chk("rj_valid", 32'(out_valid), 32'd0);
        chk("rj_busy", 32'(busy), 32'd0);
        chk("rj_data", 32'(out_data), 32'd0);
        chk("rj_raddr", 32'(read_address), 32'd0);
        step();
        reset  = 1'b0;
        dcount = 0;
        for (int k = 0; k < 5; k++) begin
            if (done === 1'b1 || out_valid === 1'b1) dcount++;
            step();
        end
        chk("rj_quiet", 32'(dcount), 32'd0);

        // full-depth job from base 7
        job(10'd7, 11'd1024, 6'b111111, 1, 1'b0);
        bad = 0;
        for (int i = 0; i < got.size(); i++)
            if (got[i] !== 16'(((7 + i) % 1024) + 'h100)) bad++;
        chk("full_count", 32'(got.size()), 32'd1024);
        chk("full_seq_bad", 32'(bad), 32'd0);
        chk("full_final", 32'(got[1023]), 32'h106);
        chk("full_done_cyc", 32'(done_cyc), 32'd1025);
`ifdef RAM_STREAM_LAST_EN
        chk("full_last_n", 32'(last_at.size()), 32'd1);
        chk("full_last_at", 32'(last_at[0]), 32'd1024);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
